// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage ARM core: stalls, flushes and operand
// forwarding from a shadow E/M/W register-address pipeline, plus counters.
module hazard_ctrl #(
  parameter int REGW = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] RA1D,
  input  logic [REGW-1:0] RA2D,
  input  logic [REGW-1:0] WA3D,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            PCSrcD,
  input  logic            RegWriteEO,
  input  logic            PCSrcEO,
  input  logic            BranchEO,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [CNTW-1:0] StallCnt,
  output logic [CNTW-1:0] FlushCnt
);

  localparam logic [REGW-1:0] PC_REG = '1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef struct packed {
    logic [REGW-1:0] ra1;
    logic [REGW-1:0] ra2;
    logic [REGW-1:0] wa3;
    logic            regwr;
    logic            memtoreg;
  } e_t;

  typedef struct packed {
    logic [REGW-1:0] wa3;
    logic            regwr;
    logic            pcsrc;
  } mw_t;

  e_t              e_q, e_d;
  mw_t             m_q, m_d;
  mw_t             w_q, w_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

  logic            ldr_stall;
  logic            pc_wr_pend;
  logic            stall_f;
  logic            stall_d;
  logic            flush_d;
  logic            flush_e;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  // Unconditioned write enable: the load's condition is not resolved yet.
  always_comb begin
    ldr_stall  = e_q.memtoreg & e_q.regwr &
                 ((e_q.wa3 == RA1D) | (e_q.wa3 == RA2D));
    pc_wr_pend = PCSrcD | PCSrcEO | m_q.pcsrc;
    stall_f    = ldr_stall | pc_wr_pend;
    stall_d    = ldr_stall;
    flush_d    = pc_wr_pend | w_q.pcsrc | BranchEO;
    flush_e    = ldr_stall | BranchEO;
  end

  always_comb begin
    fwd_a = FWD_RF;
    if (m_q.regwr && (m_q.wa3 == e_q.ra1) && (e_q.ra1 != PC_REG)) begin
      fwd_a = FWD_M;
    end else if (w_q.regwr && (w_q.wa3 == e_q.ra1) &&
                 (e_q.ra1 != PC_REG)) begin
      fwd_a = FWD_W;
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (m_q.regwr && (m_q.wa3 == e_q.ra2) && (e_q.ra2 != PC_REG)) begin
      fwd_b = FWD_M;
    end else if (w_q.regwr && (w_q.wa3 == e_q.ra2) &&
                 (e_q.ra2 != PC_REG)) begin
      fwd_b = FWD_W;
    end
  end

  // A stalled decode is never copied into E; it re-enters next cycle.
  always_comb begin
    e_d = '0;
    if (!(flush_e || stall_d)) begin
      e_d.ra1      = RA1D;
      e_d.ra2      = RA2D;
      e_d.wa3      = WA3D;
      e_d.regwr    = RegWriteD;
      e_d.memtoreg = MemtoRegD;
    end
  end

  always_comb begin
    m_d       = '0;
    m_d.wa3   = e_q.wa3;
    m_d.regwr = RegWriteEO;
    m_d.pcsrc = PCSrcEO;
    w_d       = m_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ldr_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
    if (flush_e && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Inputs can be live during reset, so the controls are masked explicitly.
  always_comb begin
    ForwardAE = reset ? fwd_a : FWD_RF;
    ForwardBE = reset ? fwd_b : FWD_RF;
    StallF    = reset & stall_f;
    StallD    = reset & stall_d;
    FlushD    = reset & flush_d;
    FlushE    = reset & flush_e;
    StallCnt  = stall_cnt_q;
    FlushCnt  = flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use stall, branch and
// PC-write flushes, reset and counter saturation on a narrow-counter copy.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, PCSrcD;
  logic        RegWriteEO, PCSrcEO, BranchEO;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [15:0] StallCnt, FlushCnt;

  logic [1:0]  s_fa, s_fb;
  logic        s_sf, s_sd, s_fd, s_fe;
  logic [3:0]  s_scnt, s_fcnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_ctrl #(.REGW(4), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .RegWriteEO(RegWriteEO), .PCSrcEO(PCSrcEO), .BranchEO(BranchEO),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  hazard_ctrl #(.REGW(4), .CNTW(4)) u_sat (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .RegWriteEO(RegWriteEO), .PCSrcEO(PCSrcEO), .BranchEO(BranchEO),
    .ForwardAE(s_fa), .ForwardBE(s_fb),
    .StallF(s_sf), .StallD(s_sd), .FlushD(s_fd), .FlushE(s_fe),
    .StallCnt(s_scnt), .FlushCnt(s_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_in(input logic [3:0] a1, input logic [3:0] a2,
                      input logic [3:0] w, input logic rw,
                      input logic m2r, input logic pc);
    RA1D = a1; RA2D = a2; WA3D = w;
    RegWriteD = rw; MemtoRegD = m2r; PCSrcD = pc;
  endtask

  task automatic eo_in(input logic rw, input logic pc, input logic br);
    RegWriteEO = rw; PCSrcEO = pc; BranchEO = br;
  endtask

  task automatic nops(input int n);
    d_in(0, 0, 0, 0, 0, 0);
    eo_in(0, 0, 0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    d_in(1, 2, 3, 1, 1, 1);
    eo_in(1, 1, 1);
    #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL rst_stallf: got %b want 0", StallF); end
    checks++; if (FlushD !== 1'b0) begin errors++; $display("FAIL rst_flushd: got %b want 0", FlushD); end
    checks++; if (FlushE !== 1'b0) begin errors++; $display("FAIL rst_flushe: got %b want 0", FlushE); end
    checks++; if (StallCnt !== 16'd0) begin errors++; $display("FAIL rst_scnt: got %0d want 0", StallCnt); end
    step();
    nops(1);
    reset = 1'b1;
    #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL rst_rel_stallf: got %b want 0", StallF); end
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL rst_rel_fwda: got %b want 00", ForwardAE); end
  endtask

  task automatic test_forward();
    nops(3);
    d_in(4, 5, 1, 1, 0, 0); eo_in(0, 0, 0);
    step();
    d_in(1, 6, 7, 1, 0, 0); eo_in(1, 0, 0);
    #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_none: got %b want 00", ForwardAE); end
    step();
    d_in(1, 0, 10, 1, 0, 0); eo_in(1, 0, 0);
    #1;
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m: got %b want 10", ForwardAE); end
    step();
    d_in(0, 0, 0, 0, 0, 0); eo_in(1, 0, 0);
    #1;
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w: got %b want 01", ForwardAE); end
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwd_w_b: got %b want 00", ForwardBE); end
    step();
  endtask

  task automatic test_r15_priority();
    nops(3);
    d_in(1, 1, 15, 1, 0, 0); eo_in(0, 0, 0);
    step();
    d_in(15, 15, 8, 1, 0, 0); eo_in(1, 0, 0);
    step();
    d_in(0, 0, 5, 1, 0, 0); eo_in(0, 0, 0);
    #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL r15_a: got %b want 00", ForwardAE); end
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL r15_b: got %b want 00", ForwardBE); end
    step();
    d_in(0, 0, 5, 1, 0, 0); eo_in(1, 0, 0);
    step();
    d_in(5, 5, 9, 1, 0, 0); eo_in(1, 0, 0);
    step();
    d_in(0, 0, 0, 0, 0, 0); eo_in(0, 0, 0);
    #1;
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL prio_a: got %b want 10", ForwardAE); end
    checks++; if (ForwardBE !== 2'b10) begin errors++; $display("FAIL prio_b: got %b want 10", ForwardBE); end
    step();
  endtask

  task automatic test_load_use();
    nops(3);
    d_in(3, 4, 2, 1, 1, 0); eo_in(0, 0, 0);
    #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL ldr_pre: got %b want 0", StallF); end
    step();
    d_in(8, 2, 9, 1, 0, 0); eo_in(1, 0, 0);
    #1;
    checks++; if (StallF !== 1'b1) begin errors++; $display("FAIL ldr_stallf: got %b want 1", StallF); end
    checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL ldr_stalld: got %b want 1", StallD); end
    checks++; if (FlushE !== 1'b1) begin errors++; $display("FAIL ldr_flushe: got %b want 1", FlushE); end
    checks++; if (FlushD !== 1'b0) begin errors++; $display("FAIL ldr_flushd: got %b want 0", FlushD); end
    step();
    exp_stall++; exp_flush++;
    eo_in(0, 0, 0);
    #1;
    checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL ldr_once: got %b want 0", StallD); end
    checks++; if (StallCnt !== 16'(exp_stall)) begin errors++; $display("FAIL ldr_scnt: got %0d want %0d", StallCnt, exp_stall); end
    step();
    d_in(0, 0, 0, 0, 0, 0); eo_in(1, 0, 0);
    #1;
    checks++; if (ForwardBE !== 2'b01) begin errors++; $display("FAIL ldr_fwdb: got %b want 01", ForwardBE); end
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL ldr_fwda: got %b want 00", ForwardAE); end
    checks++; if (FlushCnt !== 16'(exp_flush)) begin errors++; $display("FAIL ldr_fcnt: got %0d want %0d", FlushCnt, exp_flush); end
    step();
  endtask

  task automatic test_cond_fail();
    nops(3);
    d_in(0, 0, 3, 1, 0, 0); eo_in(0, 0, 0);
    step();
    d_in(3, 3, 11, 1, 0, 0); eo_in(0, 0, 0);
    step();
    d_in(3, 3, 12, 1, 0, 0); eo_in(0, 0, 0);
    #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL cf_m_a: got %b want 00", ForwardAE); end
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL cf_m_b: got %b want 00", ForwardBE); end
    step();
    d_in(0, 0, 0, 0, 0, 0); eo_in(0, 0, 0);
    #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL cf_w_a: got %b want 00", ForwardAE); end
    step();
  endtask

  task automatic test_branch();
    nops(3);
    d_in(5, 0, 6, 1, 0, 0); eo_in(0, 0, 0);
    step();
    d_in(7, 0, 8, 1, 0, 0); eo_in(0, 0, 1);
    #1;
    checks++; if (FlushD !== 1'b1) begin errors++; $display("FAIL br_flushd: got %b want 1", FlushD); end
    checks++; if (FlushE !== 1'b1) begin errors++; $display("FAIL br_flushe: got %b want 1", FlushE); end
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL br_stallf: got %b want 0", StallF); end
    step();
    exp_flush++;
    d_in(8, 8, 0, 0, 0, 0); eo_in(1, 0, 0);
    #1;
    checks++; if (FlushCnt !== 16'(exp_flush)) begin errors++; $display("FAIL br_fcnt: got %0d want %0d", FlushCnt, exp_flush); end
    checks++; if (FlushD !== 1'b0) begin errors++; $display("FAIL br_after: got %b want 0", FlushD); end
    step();
    d_in(0, 0, 0, 0, 0, 0); eo_in(0, 0, 0);
    #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL br_bubble: got %b want 00", ForwardAE); end
    step();
  endtask

  task automatic test_pc_write();
    nops(4);
    d_in(0, 0, 15, 1, 0, 1); eo_in(0, 0, 0);
    #1;
    checks++; if ({StallF, FlushD, FlushE, StallD} !== 4'b1100) begin errors++; $display("FAIL pc_d: got %b want 1100", {StallF, FlushD, FlushE, StallD}); end
    step();
    d_in(0, 0, 0, 0, 0, 0); eo_in(1, 1, 0);
    #1;
    checks++; if ({StallF, FlushD} !== 2'b11) begin errors++; $display("FAIL pc_e: got %b want 11", {StallF, FlushD}); end
    step();
    eo_in(0, 0, 0);
    #1;
    checks++; if ({StallF, FlushD} !== 2'b11) begin errors++; $display("FAIL pc_m: got %b want 11", {StallF, FlushD}); end
    step();
    checks++; if ({StallF, FlushD} !== 2'b01) begin errors++; $display("FAIL pc_w: got %b want 01", {StallF, FlushD}); end
    step();
    checks++; if ({StallF, FlushD} !== 2'b00) begin errors++; $display("FAIL pc_done: got %b want 00", {StallF, FlushD}); end
  endtask

  task automatic test_simultaneous();
    nops(4);
    d_in(0, 0, 2, 1, 1, 0); eo_in(0, 0, 0);
    step();
    d_in(2, 0, 9, 1, 0, 0); eo_in(1, 0, 1);
    #1;
    checks++; if ({StallF, StallD, FlushD, FlushE} !== 4'b1111) begin errors++; $display("FAIL br_ldr: got %b want 1111", {StallF, StallD, FlushD, FlushE}); end
    step();
    exp_stall++; exp_flush++;
    d_in(0, 0, 0, 0, 0, 0); eo_in(0, 0, 0);
    #1;
    checks++; if (StallCnt !== 16'(exp_stall)) begin errors++; $display("FAIL br_ldr_scnt: got %0d want %0d", StallCnt, exp_stall); end
    checks++; if (FlushCnt !== 16'(exp_flush)) begin errors++; $display("FAIL br_ldr_fcnt: got %0d want %0d", FlushCnt, exp_flush); end
    nops(3);
    d_in(0, 0, 4, 1, 1, 0); eo_in(0, 0, 0);
    step();
    d_in(4, 0, 15, 1, 0, 1); eo_in(1, 0, 0);
    #1;
    checks++; if ({StallF, StallD, FlushD, FlushE} !== 4'b1111) begin errors++; $display("FAIL pc_ldr: got %b want 1111", {StallF, StallD, FlushD, FlushE}); end
    step();
    exp_stall++; exp_flush++;
    d_in(0, 0, 0, 0, 0, 0); eo_in(0, 0, 0);
    #1;
    checks++; if (StallCnt !== 16'(exp_stall)) begin errors++; $display("FAIL pc_ldr_scnt: got %0d want %0d", StallCnt, exp_stall); end
    nops(3);
  endtask

  task automatic test_reset_mid_stall();
    nops(3);
    d_in(0, 0, 2, 1, 1, 0); eo_in(0, 0, 0);
    step();
    d_in(0, 2, 9, 1, 0, 1); eo_in(1, 0, 1);
    #1;
    checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b want 1", StallD); end
    reset = 1'b0;
    #1;
    checks++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin errors++; $display("FAIL mid_ctl: got %b want 0000", {StallF, StallD, FlushD, FlushE}); end
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL mid_fwd: got %b want 0000", {ForwardAE, ForwardBE}); end
    checks++; if (StallCnt !== 16'd0) begin errors++; $display("FAIL mid_scnt: got %0d want 0", StallCnt); end
    checks++; if (FlushCnt !== 16'd0) begin errors++; $display("FAIL mid_fcnt: got %0d want 0", FlushCnt); end
    exp_stall = 0; exp_flush = 0;
    step();
    eo_in(0, 0, 0);
    d_in(0, 2, 9, 1, 0, 0);
    reset = 1'b1;
    #1;
    checks++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin errors++; $display("FAIL rel_clean: got %b want 0000", {StallF, StallD, FlushD, FlushE}); end
    step();
  endtask

  task automatic test_saturation();
    nops(2);
    d_in(2, 0, 2, 1, 1, 0); eo_in(0, 0, 0);
    repeat (40) step();
    exp_stall += 20; exp_flush += 20;
    checks++; if (StallCnt !== 16'(exp_stall)) begin errors++; $display("FAIL sat_main_s: got %0d want %0d", StallCnt, exp_stall); end
    checks++; if (FlushCnt !== 16'(exp_flush)) begin errors++; $display("FAIL sat_main_f: got %0d want %0d", FlushCnt, exp_flush); end
    checks++; if (s_scnt !== 4'hF) begin errors++; $display("FAIL sat_stall: got %0d want 15", s_scnt); end
    checks++; if (s_fcnt !== 4'hF) begin errors++; $display("FAIL sat_flush: got %0d want 15", s_fcnt); end
    nops(2);
    checks++; if (s_scnt !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d want 15", s_scnt); end
  endtask

  initial begin
    reset = 1'b0;
    d_in(0, 0, 0, 0, 0, 0);
    eo_in(0, 0, 0);
    test_reset();
    test_forward();
    test_r15_priority();
    test_load_use();
    test_cond_fail();
    test_branch();
    test_pc_write();
    test_simultaneous();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
